// File: rtl/masked_pipe_reg.sv
// ============================================================================
// masked_pipe_reg : share-aware elastic pipeline register with optional
//                   input-stage re-masking for Boolean-masked datapaths.
// Rev 1.0
// ============================================================================
`default_nettype none

module masked_pipe_reg #(
    parameter int WIDTH   = 8,
    parameter int SHARES  = 2,
    parameter int DEPTH   = 2,
    parameter int REFRESH = 0
) (
    input  logic                                          C,
    input  logic                                          R,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [SHARES*WIDTH-1:0]                       in_data,
    input  logic [((SHARES > 1) ? (SHARES-1)*WIDTH : 1)-1:0] rnd,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [SHARES*WIDTH-1:0]                       out_data
);

    logic [DEPTH-1:0]        v_q;
    logic [DEPTH-1:0]        v_d;
    logic [SHARES*WIDTH-1:0] d_q [DEPTH];
    logic [SHARES*WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0]        w_adv;
    logic [SHARES*WIDTH-1:0] w_cap;
    logic                    w_down;

    // Re-masking touches each share only with randomness, never with another share.
    if (REFRESH != 0 && SHARES > 1) begin : g_refresh
        logic [WIDTH-1:0] w_mix;
        always_comb begin
            w_mix = '0;
            w_cap = in_data;
            for (int j = 0; j < SHARES-1; j++) begin
                w_cap[j*WIDTH +: WIDTH] = in_data[j*WIDTH +: WIDTH] ^ rnd[j*WIDTH +: WIDTH];
                w_mix = w_mix ^ rnd[j*WIDTH +: WIDTH];
            end
            w_cap[(SHARES-1)*WIDTH +: WIDTH] = in_data[(SHARES-1)*WIDTH +: WIDTH] ^ w_mix;
        end
    end else begin : g_passthru
        logic w_unused_rnd;
        assign w_cap        = in_data;
        assign w_unused_rnd = ^rnd;
    end

    always_comb begin
        w_down = out_ready;
        w_adv  = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            w_adv[k] = !v_q[k] | w_down;
            w_down   = w_adv[k];
        end

        v_d = v_q;
        d_d = d_q;
        if (w_adv[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = w_cap;
            end
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (w_adv[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    d_d[k] = d_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_masked_pipe_reg.sv
// ============================================================================
// tb_masked_pipe_reg : bench for masked_pipe_reg, one plain and one refreshing
//                      instance checked against a word-queue reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_masked_pipe_reg;

    logic C;
    logic R;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data, a_out_data;
    logic [3:0]  a_rnd;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [23:0] b_in_data, b_out_data;
    logic [15:0] b_rnd;

    masked_pipe_reg #(.WIDTH(4), .SHARES(2), .DEPTH(3), .REFRESH(0)) dut_a (
        .C(C), .R(R),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .rnd(a_rnd),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    masked_pipe_reg #(.WIDTH(8), .SHARES(3), .DEPTH(2), .REFRESH(1)) dut_b (
        .C(C), .R(R),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .rnd(b_rnd),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic [23:0] d;
        logic [7:0]  plain;
        int          e;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   e      = 0;
    bit   a_stall = 1'b0;
    bit   b_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] unmask3(input logic [23:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16];
    endfunction

    // Word-level model: a word reaches the output DEPTH-1 edges after it was
    // accepted, since nothing older is ahead of the oldest word in flight.
    task automatic cycle();
        bit   exp_rdy, exp_v, acc, pop;
        ent_t n;
        #1;
        exp_rdy = (qa.size() < 3) || a_out_ready;
        exp_v   = (qa.size() > 0) && (e >= qa[0].e + 2);
        check("a_in_ready", a_in_ready, exp_rdy);
        check("a_out_valid", a_out_valid, exp_v);
        if (exp_v) check("a_out_data", a_out_data, qa[0].d);
        acc = a_in_valid && exp_rdy;
        pop = exp_v && a_out_ready;
        a_stall = a_in_valid && !exp_rdy;
        if (pop) void'(qa.pop_front());
        if (acc) begin
            n.d = {16'h0, a_in_data}; n.plain = a_in_data; n.e = e + 1;
            qa.push_back(n);
        end

        exp_rdy = (qb.size() < 2) || b_out_ready;
        exp_v   = (qb.size() > 0) && (e >= qb[0].e + 1);
        check("b_in_ready", b_in_ready, exp_rdy);
        check("b_out_valid", b_out_valid, exp_v);
        if (exp_v) begin
            check("b_out_data", b_out_data, qb[0].d);
            check("b_unmasked", unmask3(b_out_data), qb[0].plain);
        end
        acc = b_in_valid && exp_rdy;
        pop = exp_v && b_out_ready;
        b_stall = b_in_valid && !exp_rdy;
        if (pop) void'(qb.pop_front());
        if (acc) begin
            n.d[7:0]   = b_in_data[7:0]   ^ b_rnd[7:0];
            n.d[15:8]  = b_in_data[15:8]  ^ b_rnd[15:8];
            n.d[23:16] = b_in_data[23:16] ^ b_rnd[7:0] ^ b_rnd[15:8];
            n.plain    = unmask3(b_in_data);
            n.e        = e + 1;
            qb.push_back(n);
        end

        @(posedge C);
        e++;
        #1;
    endtask

    initial begin
        R = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'($urandom); a_rnd = 4'($urandom); a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 24'($urandom); b_rnd = 16'($urandom); b_out_ready = 1'b0;

        // Reset holds everything empty regardless of the inputs.
        repeat (2) @(posedge C);
        #2;
        check("rst_a_in_ready", a_in_ready, 1'b1);
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_out_data", a_out_data, 8'h00);
        check("rst_b_in_ready", b_in_ready, 1'b1);
        check("rst_b_out_valid", b_out_valid, 1'b0);
        check("rst_b_out_data", b_out_data, 24'h0);
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        R = 1'b1;
        @(posedge C); #1;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (3) cycle();

        // Latency and back-to-back streaming.
        a_in_valid = 1'b1; a_in_data = 8'h5A;
        cycle();
        a_in_valid = 1'b0;
        cycle();
        cycle();
        #1 check("lat_a_out_valid", a_out_valid, 1'b1);
        check("lat_a_out_data", a_out_data, 8'h5A);
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(i);
            cycle();
        end
        a_in_valid = 1'b0;
        repeat (4) cycle();

        // Fill with a stalled output, then shift through the full pipe.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 8'h11; cycle();
        a_in_data = 8'h22; cycle();
        a_in_data = 8'h33; cycle();
        a_in_data = 8'h44;
        #1 check("full_in_ready", a_in_ready, 1'b0);
        check("full_hold_data", a_out_data, 8'h11);
        cycle();
        a_out_ready = 1'b1;
        cycle();
        a_in_valid = 1'b0;
        repeat (5) cycle();

        // Bubble collapse behind a stalled output stage.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hB1; cycle();
        a_in_valid = 1'b0; repeat (2) cycle();
        a_in_valid = 1'b1; a_in_data = 8'hB2; cycle();
        a_in_data = 8'hB3; cycle();
        a_in_data = 8'hB4;
        #1 check("bubble_refuse", a_in_ready, 1'b0);
        cycle();
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (5) cycle();

        // Share refresh on the three-share instance.
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 24'h0000A5; b_rnd = 16'hC33C;
        cycle();
        b_in_valid = 1'b0;
        cycle();
        #1 check("refresh_shares", b_out_data, 24'hFFC399);
        for (int i = 0; i < 3; i++) begin
            b_rnd = 16'($urandom); b_in_data = 24'($urandom);
            cycle();
        end
        #1 check("refresh_rnd_ignored", b_out_data, 24'hFFC399);
        b_out_ready = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset with words in flight.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hC1; cycle();
        a_in_data = 8'hC2; cycle();
        a_in_valid = 1'b0; cycle();
        #1 check("pre_rst_out_valid", a_out_valid, 1'b1);
        #1 R = 1'b0;
        #1 check("async_rst_out_valid", a_out_valid, 1'b0);
        check("async_rst_out_data", a_out_data, 8'h00);
        qa.delete(); qb.delete();
        a_stall = 1'b0; b_stall = 1'b0;
        #1 R = 1'b1;
        a_out_ready = 1'b1;
        repeat (4) cycle();

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            if (!a_stall) begin
                a_in_valid = 1'($urandom_range(0, 1));
                a_in_data  = 8'($urandom);
            end
            a_rnd = 4'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            if (!b_stall) begin
                b_in_valid = 1'($urandom_range(0, 1));
                b_in_data  = 24'($urandom);
                b_rnd      = 16'($urandom);
            end
            b_out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (6) cycle();
        check("drain_a_empty", qa.size(), 0);
        check("drain_b_empty", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
